// File: rtl/arb2to1_stream.sv
// Two-source stream arbiter with alternating tie-break priority and a single registered output slot.
// Optional per-source accepted-transfer counters are enabled by defining ARB_GRANT_CNT_EN.
module arb2to1_stream #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_a_valid,
    input  logic [DW-1:0] in_a,
    output logic          o_a_ready,
    input  logic          in_b_valid,
    input  logic [DW-1:0] in_b,
    output logic          o_b_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_result,
    output logic          o_selector,
    input  logic          in_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [7:0]    o_cnt_a,
    output logic [7:0]    o_cnt_b
`endif
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e         prio_q;
    logic          valid_q, valid_d;
    logic [DW-1:0] result_q, result_d;
    logic          sel_q, sel_d;
    logic          load;
    logic          grant_a, grant_b;

    // A source alone always wins; on a tie the priority state decides.
    // Reset suppresses every grant so no word is consumed while rst is high.
    always_comb begin
        load    = !valid_q || in_ready;
        grant_a = !rst && load && in_a_valid && (!in_b_valid || prio_q == PRIO_A);
        grant_b = !rst && load && in_b_valid && (!in_a_valid || prio_q == PRIO_B);
    end

    assign o_a_ready  = grant_a;
    assign o_b_ready  = grant_b;
    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_selector = sel_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        sel_d    = sel_q;
        if (grant_a) begin
            valid_d  = 1'b1;
            result_d = in_a;
            sel_d    = 1'b1;
        end else if (grant_b) begin
            valid_d  = 1'b1;
            result_d = in_b;
            sel_d    = 1'b0;
        end else if (load) begin
            valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q   <= PRIO_A;
            valid_q  <= 1'b0;
            result_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            sel_q    <= sel_d;
            if (grant_a) begin
                prio_q <= PRIO_B;
            end else if (grant_b) begin
                prio_q <= PRIO_A;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [7:0] cnt_a_q, cnt_a_d;
    logic [7:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (grant_a && cnt_a_q != 8'hFF) cnt_a_d = cnt_a_q + 8'd1;
        if (grant_b && cnt_b_q != 8'hFF) cnt_b_d = cnt_b_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign o_cnt_a = cnt_a_q;
    assign o_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_arb2to1_stream.sv
// Scoreboard bench for arb2to1_stream: a round-robin reference model predicts grants and the
// ordered output stream; an independent monitor pops and compares every word taken downstream.
module tb_arb2to1_stream;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          in_a_valid, in_b_valid, in_ready;
    logic [DW-1:0] in_a, in_b;
    logic          a_ready, b_ready;
    logic          o_valid, o_selector;
    logic [DW-1:0] o_result;
`ifdef ARB_GRANT_CNT_EN
    logic [7:0]    cnt_a, cnt_b;
`endif

    arb2to1_stream #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_a_valid (in_a_valid),
        .in_a       (in_a),
        .o_a_ready  (a_ready),
        .in_b_valid (in_b_valid),
        .in_b       (in_b),
        .o_b_ready  (b_ready),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_selector (o_selector),
        .in_ready   (in_ready)
`ifdef ARB_GRANT_CNT_EN
        ,
        .o_cnt_a    (cnt_a),
        .o_cnt_b    (cnt_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Expected output stream: {selector, data} in acceptance order.
    logic [DW:0]   exp_q[$];

    // Reference model state: who had the last grant, whether the output slot is full.
    bit            m_last_was_a;
    bit            m_ov;
    int            m_cnt_a, m_cnt_b;
    bit            a_pend, b_pend;
    logic [DW-1:0] a_data, b_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last_was_a = 1'b0;
        m_ov         = 1'b0;
        m_cnt_a      = 0;
        m_cnt_b      = 0;
        a_pend       = 1'b0;
        b_pend       = 1'b0;
    endtask

    // Enters at edge+2, leaves at the following edge+2.
    task automatic do_reset();
        rst        = 1'b1;
        in_a_valid = 1'b1;
        in_b_valid = 1'b1;
        in_a       = 4'h7;
        in_b       = 4'h9;
        in_ready   = 1'b1;
        model_reset();
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_selector", o_selector, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
`ifdef ARB_GRANT_CNT_EN
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
`endif
        @(posedge clk);
        #2;
        in_a_valid = 1'b0;
        in_b_valid = 1'b0;
        rst        = 1'b0;
    endtask

    // One clock cycle: optionally offer a new word per idle source, predict and check grants.
    task automatic step(input bit a_new, input logic [DW-1:0] a_d,
                        input bit b_new, input logic [DW-1:0] b_d, input bit rdy);
        bit load, ga, gb;
        if (!a_pend && a_new) begin a_pend = 1'b1; a_data = a_d; end
        if (!b_pend && b_new) begin b_pend = 1'b1; b_data = b_d; end
        in_a_valid = a_pend;
        in_a       = a_pend ? a_data : DW'($urandom);
        in_b_valid = b_pend;
        in_b       = b_pend ? b_data : DW'($urandom);
        in_ready   = rdy;
        #2;
        load = !m_ov || rdy;
        ga   = load && a_pend && (!b_pend || !m_last_was_a);
        gb   = load && b_pend && (!a_pend || m_last_was_a);
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        check("o_valid", o_valid, m_ov);
        if (ga) begin
            exp_q.push_back({1'b1, a_data});
            m_last_was_a = 1'b1;
            m_ov         = 1'b1;
            if (m_cnt_a < 255) m_cnt_a++;
        end else if (gb) begin
            exp_q.push_back({1'b0, b_data});
            m_last_was_a = 1'b0;
            m_ov         = 1'b1;
            if (m_cnt_b < 255) m_cnt_b++;
        end else if (load) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #2;
        if (ga) a_pend = 1'b0;
        if (gb) b_pend = 1'b0;
    endtask

    // Monitor: the word on the output is consumed whenever downstream is ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_valid && in_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word: got %0h expected none at %0t",
                             {o_selector, o_result}, $time);
                end else begin
                    check("out_word", {o_selector, o_result}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        in_a_valid = 1'b0;
        in_b_valid = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_ready   = 1'b0;
        do_reset();

        // Single A word straight after reset.
        step(1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Continuous contention from reset: A,B,A,B with no idle cycles.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 4'hA, 1'b1, 4'h3, 1'b1);

        // Back-pressure for 3 cycles while both sources wait, then resume.
        do_reset();
        step(1'b1, 4'h1, 1'b1, 4'h2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h4, 1'b1, 4'h6, 1'b0);
        check("held_result", o_result, 4'h1);
        check("held_selector", o_selector, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'h8, 1'b1, 4'h9, 1'b1);

        // Asynchronous reset in mid-cycle discards a held word.
        do_reset();
        step(1'b1, 4'hC, 1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        check("pre_rst_result", o_result, 4'hC);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_result", o_result, 0);
        check("async_rst_selector", o_selector, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 4'hD, 1'b1, 4'hE, 1'b1);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

        // Every data value through each source alone.
        for (int v = 0; v < 2**DW; v++) step(1'b1, DW'(v), 1'b0, 4'h0, 1'b1);
        for (int v = 0; v < 2**DW; v++) step(1'b0, 4'h0, 1'b1, DW'(v), 1'b1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < 60, DW'($urandom),
                 $urandom_range(99) < 60, DW'($urandom),
                 $urandom_range(99) < 70);
        end

`ifdef ARB_GRANT_CNT_EN
        check("cnt_a_random", cnt_a, m_cnt_a);
        check("cnt_b_random", cnt_b, m_cnt_b);
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, DW'($urandom), 1'b0, 4'h0, 1'b1);
        check("cnt_a_sat", cnt_a, 8'd255);
        check("cnt_b_zero", cnt_b, 8'd0);
`endif

        // Drain everything still pending or in flight.
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !a_pend && !b_pend && !m_ov) break;
            step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        end
        check("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
